// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment readback decoder.
// Segment order is {a,b,c,d,e,f,g} with a at the MSB; all patterns are active-low.
package seg7_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam int unsigned BUS_W     = 2 * SEG_W;
    localparam int unsigned DIG_W     = 4;
    localparam int unsigned VAL_W     = 6;
    localparam int unsigned SUM_W     = 7;
    localparam int unsigned ERR_CNT_W = 8;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0001100   // 9
    };

    typedef enum logic [1:0] {
        WAIT,
        PRESENT,
        DONE
    } state_t;

    // Decoded result carried from the combinational decode into the output registers.
    typedef struct packed {
        logic [VAL_W-1:0] value;
        logic             err;
    } seg7_result_t;

endpackage

// File: rtl/seg7_digit_enc.sv
// Combinational inverse of one seven-segment digit: pattern -> digit 0..9.
module seg7_digit_enc
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pat,
    output logic [DIG_W-1:0] digit,
    output logic             is_digit,
    output logic             is_blank
);

    // Table lookup against the canonical glyphs; unknown patterns report no digit.
    always_comb begin
        digit    = '0;
        is_digit = 1'b0;
        is_blank = (pat == SEG_BLANK);
        for (int i = 0; i < 10; i++) begin
            if (pat == SEG_DIGIT[i]) begin
                digit    = DIG_W'(i);
                is_digit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_pair_encoder.sv
// Two-digit seven-segment readback: waits for a stable bus, decodes it to 0..63
// and presents the result once per distinct pattern on a valid/ready handshake.
// Optional saturating error counter enabled with `define SEG7_ERR_COUNT_EN.
module seg7_pair_encoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BUS_W-1:0] seg_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [VAL_W-1:0] value,
    output logic             err
`ifdef SEG7_ERR_COUNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

    logic [BUS_W-1:0]  seg_q;
    logic [BUS_W-1:0]  cap_pat;
    logic [BUS_W-1:0]  cap_pat_d;
    logic [STAB_W-1:0] stab_cnt;
    state_t            state_q;
    state_t            state_d;
    logic              out_valid_d;
    logic [VAL_W-1:0]  value_d;
    logic              err_d;
    logic              stable;

    logic [DIG_W-1:0]  tens_digit;
    logic              tens_is_digit;
    logic              tens_is_blank;
    logic [DIG_W-1:0]  ones_digit;
    logic              ones_is_digit;
    logic              ones_is_blank;
    logic [DIG_W-1:0]  tens_val;
    logic              tens_ok;
    logic              ones_ok;
    logic [SUM_W-1:0]  sum;
    seg7_result_t      dec;

    seg7_digit_enc u_tens (
        .pat      (seg_q[BUS_W-1:SEG_W]),
        .digit    (tens_digit),
        .is_digit (tens_is_digit),
        .is_blank (tens_is_blank)
    );

    seg7_digit_enc u_ones (
        .pat      (seg_q[SEG_W-1:0]),
        .digit    (ones_digit),
        .is_digit (ones_is_digit),
        .is_blank (ones_is_blank)
    );

    // Input sampling and stability counter; any change on the bus restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q    <= '1;
            stab_cnt <= '0;
        end else begin
            seg_q <= seg_in;
            if (seg_in != seg_q) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_W'(STABLE_CYCLES)) begin
                stab_cnt <= stab_cnt + STAB_W'(1);
            end
        end
    end

    // Field legality, range check and binary value of the sampled pattern.
    always_comb begin
        tens_ok   = tens_is_blank ||
                    (tens_is_digit && (tens_digit >= DIG_W'(1)) && (tens_digit <= DIG_W'(6)));
        ones_ok   = ones_is_digit && !ones_is_blank;
        tens_val  = tens_is_blank ? '0 : tens_digit;
        sum       = SUM_W'(SUM_W'(tens_val) * SUM_W'(10) + SUM_W'(ones_digit));
        dec.err   = !tens_ok || !ones_ok || (sum > SUM_W'(63)) || (seg_q == '1);
        dec.value = dec.err ? '0 : sum[VAL_W-1:0];
    end

    // A counter already past the threshold (bus settled while busy) also qualifies.
    assign stable = (seg_in == seg_q) && (stab_cnt >= STAB_W'(STABLE_CYCLES - 1));

    // Next state and next output values.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid;
        value_d     = value;
        err_d       = err;
        cap_pat_d   = cap_pat;
        unique case (state_q)
            WAIT: begin
                if (stable) begin
                    cap_pat_d   = seg_q;
                    value_d     = dec.value;
                    err_d       = dec.err;
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (seg_in != cap_pat) begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = WAIT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= WAIT;
            out_valid <= 1'b0;
            value     <= '0;
            err       <= 1'b0;
            cap_pat   <= '1;
        end else begin
            state_q   <= state_d;
            out_valid <= out_valid_d;
            value     <= value_d;
            err       <= err_d;
            cap_pat   <= cap_pat_d;
        end
    end

`ifdef SEG7_ERR_COUNT_EN
    // Count accepted error results, saturating at full scale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if ((state_q == PRESENT) && out_ready && err && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_seg7_pair_encoder.sv
// Scoreboard bench for seg7_pair_encoder; also covers err_count when SEG7_ERR_COUNT_EN is defined.
module tb_seg7_pair_encoder;

    localparam int unsigned STABLE_CYCLES = 4;

    localparam logic [13:0] P42    = 14'b1001100_0010010;
    localparam logic [13:0] P00    = 14'b1111111_0000001;
    localparam logic [13:0] P63    = 14'b0100000_0000110;
    localparam logic [13:0] P64    = 14'b0100000_1001100;
    localparam logic [13:0] PBLANK = 14'h3FFF;
    localparam logic [13:0] PT0    = 14'b0000001_0000001;
    localparam logic [13:0] POI    = 14'b1111111_1111110;
    localparam logic [13:0] P60    = 14'b0100000_0000001;
    localparam logic [13:0] P59    = 14'b0100100_0001100;
    localparam logic [13:0] P17    = 14'b1001111_0001111;
    localparam logic [13:0] P25    = 14'b0010010_0100100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] seg_in = P42;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [5:0]  value;
    logic        err;
`ifdef SEG7_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    seg7_pair_encoder #(.STABLE_CYCLES(STABLE_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .value     (value),
        .err       (err)
`ifdef SEG7_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] value;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: reset values, hold/drop behaviour and scoreboard pop on each new result.
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       prst = 1'b0;
    logic [5:0] pval = '0;
    logic       perr = 1'b0;

    always @(negedge clk) begin
        if (!prst) begin
            chk("reset_valid", int'(out_valid), 0);
            chk("reset_value", int'(value), 0);
            chk("reset_err", int'(err), 0);
`ifdef SEG7_ERR_COUNT_EN
            chk("reset_err_count", int'(err_count), 0);
`endif
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_value", int'(value), int'(pval));
                chk("hold_err", int'(err), int'(perr));
            end else if (pv && pr) begin
                chk("handshake_drop", int'(out_valid), 0);
            end
            if (out_valid && !pv) begin
                seen++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got value %0d err %0b at edge %0d, want no result",
                             value, err, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk({mon_e.name, "_value"}, int'(value), int'(mon_e.value));
                    chk({mon_e.name, "_err"}, int'(err), int'(mon_e.err));
                    if (mon_e.cyc != 0) chk({mon_e.name, "_edge"}, cyc, mon_e.cyc);
                end
            end
        end
        pv   = out_valid;
        pr   = out_ready;
        prst = rst_n;
        pval = value;
        perr = err;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string name, input logic [5:0] v, input logic e, input int dt);
        exp_t x;
        x.name  = name;
        x.value = v;
        x.err   = e;
        x.cyc   = (dt == 0) ? 0 : cyc + dt;
        exp_q.push_back(x);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            step(1);
            n++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results and out_valid %0b, want none",
                     exp_q.size(), out_valid);
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            step(1);
            n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL valid_timeout: got out_valid 0 after %0d edges, want 1", budget);
        end
    endtask

    task automatic send(input string name, input logic [13:0] p, input logic [5:0] v, input logic e);
        seg_in = p;
        expect_res(name, v, e, STABLE_CYCLES + 1);
        drain(40);
    endtask

    initial begin
        int seen0;

        step(3);
        rst_n = 1'b1;
        expect_res("first_42", 6'd42, 1'b0, STABLE_CYCLES + 1);
        drain(40);

        send("zero", P00, 6'd0, 1'b0);
        send("max_63", P63, 6'd63, 1'b0);
        send("range_64", P64, 6'd0, 1'b1);
        send("all_blank", PBLANK, 6'd0, 1'b1);
        send("tens_zero_glyph", PT0, 6'd0, 1'b1);
        send("ones_illegal", POI, 6'd0, 1'b1);
`ifdef SEG7_ERR_COUNT_EN
        chk("err_count_after_errors", int'(err_count), 4);
`endif
        send("sixty", P60, 6'd60, 1'b0);
        send("fifty_nine", P59, 6'd59, 1'b0);

        // Backpressure: result held while the bus moves on, next pattern follows acceptance.
        out_ready = 1'b0;
        seg_in = P42;
        expect_res("held_42", 6'd42, 1'b0, STABLE_CYCLES + 1);
        wait_valid(20);
        seg_in = P17;
        step(10);
        chk("held_valid", int'(out_valid), 1);
        chk("held_value", int'(value), 42);
        expect_res("after_hold_17", 6'd17, 1'b0, 3);
        out_ready = 1'b1;
        drain(40);

        // One-cycle glitch restarts the stability window.
        seg_in = P25;
        step(3);
        seg_in = 14'h0000;
        step(1);
        seg_in = P25;
        expect_res("glitch_25", 6'd25, 1'b0, STABLE_CYCLES + 1);
        drain(40);

        seen0 = seen;
        step(100);
        chk("no_reemit", seen, seen0);

        // Reset while presenting discards the result; the held pattern comes back.
        out_ready = 1'b0;
        seg_in = P42;
        expect_res("pre_reset_42", 6'd42, 1'b0, STABLE_CYCLES + 1);
        wait_valid(20);
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        expect_res("post_reset_42", 6'd42, 1'b0, STABLE_CYCLES + 1);
        drain(40);
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
